mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// 32-bit word memory for a CPU, with an optional boot loader front end.
// The loader is built only when MEM_RESPONDER_LOADER_EN is defined.
module mem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [31:0]   address,
  input  logic [31:0]   data_out,
  input  logic          r_en_mem,
  input  logic          w_en_mem,
  output logic [31:0]   MemData,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          cpu_rst_out,
  output logic [AW:0]   words_loaded
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic          w_run;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;
  logic          w_unused_addr;

  assign w_idx         = address[AW+1:2];
  assign w_unused_addr = ^{address[1:0], address[31:AW+2]};

  assign MemData = (w_run && r_en_mem) ? r_mem[w_idx] : 32'h0;

  // Memory is never reset; boot image survives a CPU reset.
  always_ff @(posedge clk_in) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

`ifdef MEM_RESPONDER_LOADER_EN

  typedef enum logic [1:0] {
    S_LOAD,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam logic [AW:0] LastCnt = (AW+1)'(DEPTH - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [AW:0] r_words;
  logic [AW:0] w_words_nxt;
  logic        w_xfer;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_LOAD;
      r_words <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_words <= w_words_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_words_nxt = r_words;
    w_xfer      = 1'b0;
    ld_ready    = 1'b0;
    cpu_rst_out = 1'b1;
    w_run       = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          w_xfer      = 1'b1;
          w_words_nxt = r_words + 1'b1;
          // Stop at a full memory so no word wraps onto index 0.
          if (ld_last || r_words == LastCnt) begin
            w_state_nxt = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        cpu_rst_out = 1'b0;
        w_run       = 1'b1;
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  assign w_we    = !rst_in && (w_xfer || (w_run && w_en_mem));
  assign w_waddr = w_xfer ? r_words[AW-1:0] : w_idx;
  assign w_wdata = w_xfer ? ld_data : data_out;

  assign words_loaded = r_words;

`else

  logic r_cpu_rst;
  logic w_unused_ld;

  always_ff @(posedge clk_in) begin
    r_cpu_rst <= rst_in;
  end

  assign w_unused_ld  = ^{ld_valid, ld_data, ld_last};
  assign w_run        = 1'b1;
  assign ld_ready     = 1'b0;
  assign words_loaded = '0;
  assign cpu_rst_out  = r_cpu_rst;

  assign w_we    = !rst_in && w_en_mem;
  assign w_waddr = w_idx;
  assign w_wdata = data_out;

`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder, covering the build selected
// by MEM_RESPONDER_LOADER_EN.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ren;
  logic        wen;
  logic [31:0] rdata;
  logic        ldv;
  logic [31:0] ldd;
  logic        ldl;
  logic        ldr;
  logic        crst;
  logic [10:0] wl;

  logic        s_rst;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_ren;
  logic        s_wen;
  logic [31:0] s_rdata;
  logic        s_ldv;
  logic [31:0] s_ldd;
  logic        s_ldl;
  logic        s_ldr;
  logic        s_crst;
  logic [2:0]  s_wl;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder u_dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .address      (addr),
    .data_out     (wdata),
    .r_en_mem     (ren),
    .w_en_mem     (wen),
    .MemData      (rdata),
    .ld_valid     (ldv),
    .ld_data      (ldd),
    .ld_last      (ldl),
    .ld_ready     (ldr),
    .cpu_rst_out  (crst),
    .words_loaded (wl)
  );

  mem_responder #(
    .DEPTH (4),
    .AW    (2)
  ) u_small (
    .clk_in       (clk),
    .rst_in       (s_rst),
    .address      (s_addr),
    .data_out     (s_wdata),
    .r_en_mem     (s_ren),
    .w_en_mem     (s_wen),
    .MemData      (s_rdata),
    .ld_valid     (s_ldv),
    .ld_data      (s_ldd),
    .ld_last      (s_ldl),
    .ld_ready     (s_ldr),
    .cpu_rst_out  (s_crst),
    .words_loaded (s_wl)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_rd(input logic [31:0] a);
    addr = a;
    ren  = 1'b1;
    wen  = 1'b0;
    #1;
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    ren   = 1'b0;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
  endtask

  task automatic ld_word(input logic [31:0] d, input logic last);
    ldv = 1'b1;
    ldd = d;
    ldl = last;
    tick();
    ldv = 1'b0;
    ldl = 1'b0;
  endtask

  task automatic cpu_tests;
    cpu_wr(32'h10, 32'hDEADBEEF);
    cpu_rd(32'h10);
    chk("rd_10", rdata, 32'hDEADBEEF);
    cpu_rd(32'h13);
    chk("rd_13_alias", rdata, 32'hDEADBEEF);
    cpu_rd(32'h1010);
    chk("rd_1010_alias", rdata, 32'hDEADBEEF);
    ren = 1'b0;
    #1;
    chk("rd_off_zero", rdata, 32'h0);
    addr  = 32'h10;
    wdata = 32'h1;
    ren   = 1'b1;
    wen   = 1'b1;
    #1;
    chk("rw_old_data", rdata, 32'hDEADBEEF);
    tick();
    wen = 1'b0;
    #1;
    chk("rw_new_data", rdata, 32'h1);
    ren = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; ren = 1'b0; wen = 1'b0;
    ldv = 1'b0; ldd = '0; ldl = 1'b0;
    s_rst = 1'b1; s_addr = '0; s_wdata = '0; s_ren = 1'b0;
    s_wen = 1'b0; s_ldv = 1'b0; s_ldd = '0; s_ldl = 1'b0;

`ifdef MEM_RESPONDER_LOADER_EN
    tick();
    rst = 1'b0;
    chk("rst_ld_ready", 32'(ldr), 32'h1);
    chk("rst_cpu_rst", 32'(crst), 32'h1);
    chk("rst_words", 32'(wl), 32'h0);
    cpu_rd(32'h0);
    chk("load_rd_zero", rdata, 32'h0);
    ren = 1'b0;

    // Reset in the middle of a load
    ld_word(32'h11111111, 1'b0);
    ld_word(32'h22222222, 1'b0);
    chk("mid_words2", 32'(wl), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_words", 32'(wl), 32'h0);
    ld_word(32'h33333333, 1'b1);
    chk("mid_release_crst", 32'(crst), 32'h1);
    chk("mid_release_ldr", 32'(ldr), 32'h0);
    tick();
    chk("mid_run_crst", 32'(crst), 32'h0);
    cpu_rd(32'h0);
    chk("mid_idx0_new", rdata, 32'h33333333);
    cpu_rd(32'h4);
    chk("mid_idx1_kept", rdata, 32'h22222222);
    ren = 1'b0;

    // Boot sequence with a gap cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_word(32'h00000093, 1'b0);
    ldv = 1'b0;
    ldd = 32'h00000BAD;
    tick();
    chk("gap_words", 32'(wl), 32'h1);
    ld_word(32'h00100113, 1'b0);
    chk("boot_words2", 32'(wl), 32'h2);
    ld_word(32'h002081B3, 1'b1);
    chk("boot_release_crst", 32'(crst), 32'h1);
    chk("boot_release_ldr", 32'(ldr), 32'h0);
    chk("boot_words3", 32'(wl), 32'h3);
    tick();
    chk("boot_run_crst", 32'(crst), 32'h0);
    cpu_rd(32'h8);
    chk("boot_rd_8", rdata, 32'h002081B3);
    cpu_rd(32'h4);
    chk("boot_rd_4", rdata, 32'h00100113);
    ren = 1'b0;

    // Loader held valid while running
    ldv = 1'b1;
    ldd = 32'hFFFFFFFF;
    tick();
    tick();
    chk("run_ldr", 32'(ldr), 32'h0);
    chk("run_words_hold", 32'(wl), 32'h3);
    cpu_rd(32'h0);
    chk("run_ld_ignored", rdata, 32'h00000093);
    ren = 1'b0;
    ldv = 1'b0;

    cpu_tests();

    // Reset discards a coincident CPU write, keeps memory
    addr  = 32'h10;
    wdata = 32'h55;
    wen   = 1'b1;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    wen = 1'b0;
    chk("rrst_ldr", 32'(ldr), 32'h1);
    chk("rrst_crst", 32'(crst), 32'h1);
    chk("rrst_words", 32'(wl), 32'h0);
    ld_word(32'h00000093, 1'b1);
    tick();
    cpu_rd(32'h10);
    chk("rrst_write_dropped", rdata, 32'h1);
    cpu_rd(32'h8);
    chk("rrst_mem_kept", rdata, 32'h002081B3);
    ren = 1'b0;

    // Overflow on the 4-word instance
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_ldv = 1'b1;
      s_ldd = 32'hA0 + 32'(i);
      s_ldl = 1'b0;
      tick();
    end
    chk("ovf_ldr", 32'(s_ldr), 32'h0);
    chk("ovf_crst", 32'(s_crst), 32'h1);
    chk("ovf_words", 32'(s_wl), 32'h4);
    s_ldd = 32'hEEEE;
    tick();
    chk("ovf_run_crst", 32'(s_crst), 32'h0);
    tick();
    s_ldv = 1'b0;
    chk("ovf_words_hold", 32'(s_wl), 32'h4);
    s_ren  = 1'b1;
    s_addr = 32'h0;
    #1;
    chk("ovf_idx0", s_rdata, 32'hA0);
    s_addr = 32'hC;
    #1;
    chk("ovf_idx3", s_rdata, 32'hA3);
    s_ren = 1'b0;
`else
    tick();
    tick();
    chk("rst_cpu_rst", 32'(crst), 32'h1);
    chk("rst_ld_ready", 32'(ldr), 32'h0);
    chk("rst_words", 32'(wl), 32'h0);
    rst   = 1'b0;
    s_rst = 1'b0;
    #1;
    chk("post_rst_crst", 32'(crst), 32'h1);
    tick();
    chk("run_crst", 32'(crst), 32'h0);

    cpu_tests();

    cpu_wr(32'h0, 32'h12345678);
    ldv = 1'b1;
    ldd = 32'hFFFFFFFF;
    ldl = 1'b1;
    tick();
    tick();
    chk("ld_ignored_ldr", 32'(ldr), 32'h0);
    chk("ld_ignored_words", 32'(wl), 32'h0);
    cpu_rd(32'h0);
    chk("ld_ignored_mem", rdata, 32'h12345678);
    ren = 1'b0;
    ldv = 1'b0;
    ldl = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    cpu_rd(32'h10);
    chk("rst_mem_kept", rdata, 32'h1);
    ren = 1'b0;

    // 4-word instance aliasing
    s_addr  = 32'h0;
    s_wdata = 32'hA5;
    s_wen   = 1'b1;
    tick();
    s_addr  = 32'hC;
    s_wdata = 32'h5A;
    tick();
    s_wen  = 1'b0;
    s_ren  = 1'b1;
    s_addr = 32'h10;
    #1;
    chk("small_alias0", s_rdata, 32'hA5);
    s_addr = 32'h1F;
    #1;
    chk("small_alias3", s_rdata, 32'h5A);
    s_ren = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
